// File: rtl/move_link.sv
// Framed toggle-handshake message link between two boards: TX FIFO -> req/ack toggle transfer -> single-entry RX buffer.
// Latency push->pop >= 1+SETUP+2+SETTLE+accept+2 cycles; tx_ready drops on FIFO full, ack withheld while rx_valid.

module move_link_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdat    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) level_d = level_q + (AW+1)'(1);
    else if (!do_push && do_pop) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

module move_link #(
  parameter int MSG_W         = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int TIMEOUT       = 75000,
  localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MSG_W-1:0] tx_msg,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [MSG_W-1:0] rx_msg,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [MSG_W+1:0] link_out,
  input  logic [MSG_W+1:0] link_in,
  output logic [LW-1:0]    fifo_level,
  output logic             tx_timeout
);
  localparam int SUW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_WAIT} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_SETTLE, RX_HOLD} rx_state_e;

  logic [MSG_W+1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic             req_s, ack_s;
  logic [MSG_W-1:0] data_s;

  tx_state_e        tx_state_q, tx_state_d;
  logic [SUW-1:0]   setup_cnt_q, setup_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic             req_q, req_d;
  logic [MSG_W-1:0] tx_dat_q, tx_dat_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [STW-1:0]   settle_cnt_q, settle_cnt_d;
  logic             last_req_q, last_req_d;
  logic [MSG_W-1:0] rx_msg_q, rx_msg_d;
  logic             rx_vld_q, rx_vld_d;
  logic             ack_q, ack_d;

  logic [MSG_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty, fifo_pop;

  move_link_fifo #(.W(MSG_W), .DEPTH(FIFO_DEPTH)) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .wdat  (tx_msg),
    .pop   (fifo_pop),
    .rdat  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign req_s      = sync2_q[MSG_W+1];
  assign ack_s      = sync2_q[MSG_W];
  assign data_s     = sync2_q[MSG_W-1:0];
  assign tx_ready   = !fifo_full;
  assign link_out   = {req_q, ack_q, tx_dat_q};
  assign rx_msg     = rx_msg_q;
  assign rx_valid   = rx_vld_q;
  assign tx_timeout = timeout_q;

  always_comb begin
    sync1_d      = link_in;
    sync2_d      = sync1_q;
    tx_state_d   = tx_state_q;
    setup_cnt_d  = setup_cnt_q;
    timer_d      = timer_q;
    timeout_d    = timeout_q;
    req_d        = req_q;
    tx_dat_d     = tx_dat_q;
    fifo_pop     = 1'b0;
    rx_state_d   = rx_state_q;
    settle_cnt_d = settle_cnt_q;
    last_req_d   = last_req_q;
    rx_msg_d     = rx_msg_q;
    rx_vld_d     = rx_vld_q;
    ack_d        = ack_q;

    case (tx_state_q)
      TX_IDLE: if (!fifo_empty) begin
        tx_dat_d    = fifo_head;
        setup_cnt_d = '0;
        tx_state_d  = TX_SETUP;
      end
      TX_SETUP: if (setup_cnt_q == SUW'(SETUP_CYCLES - 1)) begin
        req_d      = ~req_q;
        timer_d    = '0;
        tx_state_d = TX_WAIT;
      end else begin
        setup_cnt_d = setup_cnt_q + SUW'(1);
      end
      TX_WAIT: if (ack_s == req_q) begin
        fifo_pop   = 1'b1;
        timer_d    = '0;
        tx_state_d = TX_IDLE;
      end else if (timer_q != TW'(TIMEOUT)) begin
        // Never retransmit: a resent move would be applied twice by the peer.
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(TIMEOUT - 1)) timeout_d = 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    case (rx_state_q)
      RX_IDLE: if (req_s != last_req_q) begin
        settle_cnt_d = '0;
        rx_state_d   = RX_SETTLE;
      end
      RX_SETTLE: if (settle_cnt_q == STW'(SETTLE_CYCLES - 1)) begin
        rx_msg_d   = data_s;
        rx_vld_d   = 1'b1;
        last_req_d = req_s;
        rx_state_d = RX_HOLD;
      end else begin
        settle_cnt_d = settle_cnt_q + STW'(1);
      end
      RX_HOLD: if (rx_vld_q && rx_ready) begin
        rx_vld_d   = 1'b0;
        ack_d      = ~ack_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      tx_state_q   <= TX_IDLE;
      setup_cnt_q  <= '0;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      req_q        <= 1'b0;
      tx_dat_q     <= '0;
      rx_state_q   <= RX_IDLE;
      settle_cnt_q <= '0;
      last_req_q   <= 1'b0;
      rx_msg_q     <= '0;
      rx_vld_q     <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tx_state_q   <= tx_state_d;
      setup_cnt_q  <= setup_cnt_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      req_q        <= req_d;
      tx_dat_q     <= tx_dat_d;
      rx_state_q   <= rx_state_d;
      settle_cnt_q <= settle_cnt_d;
      last_req_q   <= last_req_d;
      rx_msg_q     <= rx_msg_d;
      rx_vld_q     <= rx_vld_d;
      ack_q        <= ack_d;
    end
  end
endmodule
